// File: rtl/aes_key_schedule_if.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_if
// Bundle of the key-load request and round-key stream of aes_key_schedule.
//   start    : begin expansion (honoured only while busy=0)
//   key_size : 0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
//   key      : cipher key, left-aligned (word 0 = key[255:224])
//   busy     : expansion in progress
//   done     : one-cycle pulse after the last round-key handshake
//   rk_valid / rk_ready : round-key handshake
//   rk_data  : round key, word 0 in [127:96]
//   rk_idx   : round number 0..Nr
//   rk_last  : high with the round key whose rk_idx = Nr
// master = key consumer / controller side, slave = the expander.
// ---------------------------------------------------------------------------
interface aes_key_schedule_if;
    logic         start;
    logic [1:0]   key_size;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output start, key_size, key, rk_ready,
        input  busy, done, rk_valid, rk_data, rk_idx, rk_last
    );

    modport slave (
        input  start, key_size, key, rk_ready,
        output busy, done, rk_valid, rk_data, rk_idx, rk_last
    );
endinterface

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
// Sequential AES-128/192/256 key expander. One 32-bit schedule word per
// clock; every fourth word completes a round key that is offered on a
// valid/ready stream. Production freezes while a completed round key is
// still waiting for the consumer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_key_schedule_if.slave (start/key request, round-key stream)
//   rd_addr    : (AES_KEY_SCHEDULE_STORE_EN only) round-key store read address
//   rd_data    : (AES_KEY_SCHEDULE_STORE_EN only) registered read data, 1-cycle latency
// Parameter MAX_NK (4, 6 or 8): largest key in words; larger key_size requests
// are ignored.
// Optional feature macro: AES_KEY_SCHEDULE_STORE_EN adds a 15x128 round-key
// store written on every handshake, for reverse-order replay in decryption.
// ---------------------------------------------------------------------------
module aes_key_schedule #(
    parameter int MAX_NK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_schedule_if.slave    bus
`ifdef AES_KEY_SCHEDULE_STORE_EN
    ,
    input  logic [3:0]           rd_addr,
    output logic [127:0]         rd_data
`endif
);

    localparam int IW = $clog2(MAX_NK);

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   win_q [MAX_NK];   // newest word at MAX_NK-1
    logic [95:0]   asm_q;            // first three words of the round key being built
    logic [5:0]    i_q;              // schedule word counter
    logic [3:0]    j_q;              // i mod Nk
    logic          first_q;          // i < Nk: still emitting raw key words
    logic [3:0]    nk_q, nr_q;
    logic [7:0]    rcon_q;
    logic [127:0]  rk_data_q;
    logic [3:0]    rk_idx_q;
    logic          rk_valid_q, rk_last_q, done_q;

    // ---------------- GF(2^8) helpers and S-box ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, p;
        acc = '0;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse as x^254 = x^2*x^4*...*x^128 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // ---------------- request decode ----------------
    logic [3:0]  req_nk;
    logic        req_legal;
    logic [31:0] key_w [8];

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves a variable unassigned would infer a latch.
        req_nk = 4'd0;
        case (bus.key_size)
            2'd0:    req_nk = 4'd4;
            2'd1:    req_nk = 4'd6;
            2'd2:    req_nk = 4'd8;
            default: req_nk = 4'd0;
        endcase
        for (int n = 0; n < 8; n++) key_w[n] = bus.key[255 - 32*n -: 32];
    end

    assign req_legal = (bus.key_size != 2'd3) && (req_nk <= 4'(MAX_NK));

    // ---------------- word generation ----------------
    logic [IW-1:0] old_idx;
    logic [31:0]   w_old, w_prev, sw_in, sw_out, w_new;
    logic          completes, handshake, advance, accept, load_rk, last_word;

    assign old_idx = IW'(MAX_NK - int'(nk_q));      // position of w[i-Nk]
    assign w_old   = win_q[old_idx];
    assign w_prev  = win_q[MAX_NK-1];
    // One shared group of four S-boxes: RotWord input on i%Nk==0, plain otherwise.
    assign sw_in   = (j_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign sw_out  = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};

    always_comb begin
        w_new = w_old ^ w_prev;
        if (first_q)
            w_new = w_old;   // window was preloaded so the oldest slot walks the key
        else if (j_q == 4'd0)
            w_new = w_old ^ sw_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && j_q == 4'd4)
            w_new = w_old ^ sw_out;
    end

    assign completes = (i_q[1:0] == 2'd3);
    assign handshake = rk_valid_q && bus.rk_ready;
    assign advance   = (state_q == ST_GEN) && (!completes || !rk_valid_q || bus.rk_ready);
    assign accept    = (state_q == ST_IDLE) && bus.start && req_legal;
    assign load_rk   = advance && completes;
    assign last_word = (i_q == {nr_q, 2'b11});

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_GEN;
            ST_GEN:   if (advance && last_word) state_d = ST_DRAIN;
            ST_DRAIN: if (handshake && rk_last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_NK; k++) win_q[k] <= '0;
            asm_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            first_q    <= 1'b0;
            nk_q       <= 4'd4;
            nr_q       <= '0;
            rcon_q     <= '0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DRAIN) && handshake && rk_last_q;

            if (accept) begin
                // Key word j lands at MAX_NK-Nk+j, so w[i-Nk] is key word i while i<Nk.
                for (int k = 0; k < MAX_NK; k++) begin
                    if (k + int'(req_nk) >= MAX_NK)
                        win_q[k] <= key_w[3'(k + int'(req_nk) - MAX_NK)];
                    else
                        win_q[k] <= '0;
                end
                i_q     <= '0;
                j_q     <= '0;
                first_q <= 1'b1;
                nk_q    <= req_nk;
                nr_q    <= req_nk + 4'd6;
                rcon_q  <= 8'h01;
            end else if (advance) begin
                for (int k = 0; k < MAX_NK-1; k++) win_q[k] <= win_q[k+1];
                win_q[MAX_NK-1] <= w_new;
                asm_q <= {asm_q[63:0], w_new};
                i_q   <= i_q + 6'd1;
                if (j_q == nk_q - 4'd1) begin
                    j_q     <= '0;
                    first_q <= 1'b0;
                end else begin
                    j_q <= j_q + 4'd1;
                end
                if (!first_q && j_q == 4'd0) rcon_q <= xtime(rcon_q);
            end

            if (load_rk) begin
                rk_valid_q <= 1'b1;
                rk_data_q  <= {asm_q, w_new};
                rk_idx_q   <= i_q[5:2];
                rk_last_q  <= (i_q[5:2] == nr_q);
            end else if (handshake) begin
                rk_valid_q <= 1'b0;
            end
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk_last  = rk_last_q;

`ifdef AES_KEY_SCHEDULE_STORE_EN
    logic [127:0] store_mem [15];
    logic [14:0]  stored_q;

    // NOTE: the store array has no reset; stored_q marks which entries hold
    // a key from the current run, so unwritten entries never reach rd_data.
    always_ff @(posedge clk) begin
        if (handshake) store_mem[rk_idx_q] <= rk_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_q <= '0;
            rd_data  <= '0;
        end else begin
            if (accept)         stored_q <= '0;
            else if (handshake) stored_q[rk_idx_q] <= 1'b1;
            rd_data <= (rd_addr <= nr_q && stored_q[rd_addr]) ? store_mem[rd_addr] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
// Directed bench for aes_key_schedule: FIPS-197 key vectors for all three key
// sizes, latency to done, backpressure stability, ignored starts, mid-run
// reset, and (with AES_KEY_SCHEDULE_STORE_EN) the round-key store.
// A second instance with MAX_NK=4 covers rejection of oversize keys.
// Expected round keys come from an independent bench model whose S-box is
// generated with the log/antilog walk over generator 3.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    aes_key_schedule_if bus ();
    aes_key_schedule_if bus4 ();

`ifdef AES_KEY_SCHEDULE_STORE_EN
    logic [3:0]   rd_addr, rd_addr4;
    logic [127:0] rd_data, rd_data4;
`endif

    aes_key_schedule #(.MAX_NK(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef AES_KEY_SCHEDULE_STORE_EN
        ,
        .rd_addr (rd_addr),
        .rd_data (rd_data)
`endif
    );

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus4)
`ifdef AES_KEY_SCHEDULE_STORE_EN
        ,
        .rd_addr (rd_addr4),
        .rd_data (rd_data4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [15];
    logic [127:0] cap_rk [15];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);   // p *= 3
            q = q ^ {q[6:0], 1'b0};                             // q /= 3
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic build_expected(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_w(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++)
            exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Runs one expansion on the MAX_NK=8 instance. exp_latency=0 skips the
    // latency comparison (used under random backpressure).
    task automatic run_key(input string tag, input logic [1:0] ks, input logic [255:0] k,
                           input bit stall, input bit disturb, input int exp_latency);
        int           nk, nr, n, hs, done_n;
        logic [3:0]   next_idx, held_idx;
        logic [127:0] held_data;
        bit           held;
        nk = (ks == 2'd0) ? 4 : (ks == 2'd1) ? 6 : 8;
        nr = nk + 6;
        build_expected(k, nk);
        // NOTE: inputs change on the falling edge with blocking assignments,
        // so the design samples them cleanly at the next rising edge.
        @(negedge clk);
        bus.key      = k;
        bus.key_size = ks;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({tag, " busy after start"}, bus.busy, 1'b1);
        n = 0; hs = 0; done_n = -1; next_idx = '0; held = 0;
        held_idx = '0; held_data = '0;
        while (done_n < 0 && n < 2000) begin
            @(negedge clk);
            if (held) begin
                check({tag, " stall valid"}, bus.rk_valid, 1'b1);
                check({tag, " stall data"}, bus.rk_data, held_data);
                check({tag, " stall idx"}, bus.rk_idx, held_idx);
            end
            if (bus.done) begin
                done_n = n;
                check({tag, " busy at done"}, bus.busy, 1'b0);
            end
            bus.rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rk_valid && bus.rk_ready) begin
                check({tag, " rk_idx"}, bus.rk_idx, next_idx);
                check({tag, " rk_data"}, bus.rk_data, exp_rk[next_idx]);
                check({tag, " rk_last"}, bus.rk_last, (int'(next_idx) == nr));
                cap_rk[next_idx] = bus.rk_data;
                hs++;
                next_idx = next_idx + 4'd1;
                held = 0;
            end else if (bus.rk_valid) begin
                held      = 1;
                held_data = bus.rk_data;
                held_idx  = bus.rk_idx;
            end else begin
                held = 0;
            end
            if (disturb && n == 10) begin
                bus.start    = 1'b1;
                bus.key      = ~k;
                bus.key_size = 2'd2;
            end
            if (disturb && n == 11) bus.start = 1'b0;
            n++;
        end
        bus.rk_ready = 1'b1;
        check({tag, " done seen"}, (done_n >= 0), 1'b1);
        check({tag, " handshakes"}, hs, nr + 1);
        if (exp_latency > 0) check({tag, " start-to-done cycles"}, done_n, exp_latency);
    endtask

    initial begin
        bit seen;
        build_sbox();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key_size  = 2'd0;
        bus.key       = '0;
        bus.rk_ready  = 1'b1;
        bus4.start    = 1'b0;
        bus4.key_size = 2'd0;
        bus4.key      = '0;
        bus4.rk_ready = 1'b1;
`ifdef AES_KEY_SCHEDULE_STORE_EN
        rd_addr  = '0;
        rd_addr4 = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset rk_valid", bus.rk_valid, 1'b0);
        check("reset rk_last", bus.rk_last, 1'b0);
        check("reset rk_idx", bus.rk_idx, 4'd0);
        check("reset rk_data", bus.rk_data, 128'd0);
`ifdef AES_KEY_SCHEDULE_STORE_EN
        check("reset rd_data", rd_data, 128'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, no backpressure
        run_key("aes128", 2'd0, KEY128, 0, 0, 45);
        check("aes128 rk1 fips", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("aes128 rk10 fips", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        run_key("aes192", 2'd1, KEY192, 0, 0, 53);
        check("aes192 rk12", cap_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

        // AES-256
        run_key("aes256", 2'd2, KEY256, 0, 0, 61);
        check("aes256 rk0", cap_rk[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("aes256 rk1", cap_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
        check("aes256 rk14", cap_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // AES-256 under random backpressure
        run_key("aes256 stall", 2'd2, KEY256, 1, 0, 0);
        check("aes256 stall rk14", cap_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // start / key / key_size changes while busy have no effect
        run_key("aes128 disturb", 2'd0, KEY128, 0, 1, 45);

        // reserved key_size is ignored
        @(negedge clk);
        bus.key      = KEY256;
        bus.key_size = 2'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ks3 busy", bus.busy, 1'b0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.rk_valid | bus.busy;
        end
        check("ks3 no activity", seen, 1'b0);

        // MAX_NK=4 instance rejects AES-256
        @(negedge clk);
        bus4.key      = KEY256;
        bus4.key_size = 2'd2;
        bus4.start    = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("nk4 ks2 busy", bus4.busy, 1'b0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus4.rk_valid | bus4.busy;
        end
        check("nk4 ks2 no activity", seen, 1'b0);
        bus4.key      = KEY128;
        bus4.key_size = 2'd0;
        bus4.start    = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        check("nk4 ks0 accepted", bus4.busy, 1'b1);

        // reset in the middle of an AES-128 run (round 5 on the bus)
        @(negedge clk);
        bus.key      = KEY128;
        bus.key_size = 2'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (25) @(negedge clk);
        check("pre-reset rk_valid", bus.rk_valid, 1'b1);
        check("pre-reset rk_idx", bus.rk_idx, 4'd5);
        rst_n = 1'b0;
        #1;
        check("midreset busy", bus.busy, 1'b0);
        check("midreset rk_valid", bus.rk_valid, 1'b0);
        check("midreset rk_idx", bus.rk_idx, 4'd0);
        check("midreset rk_data", bus.rk_data, 128'd0);
        check("midreset rk_last", bus.rk_last, 1'b0);
`ifdef AES_KEY_SCHEDULE_STORE_EN
        check("midreset rd_data", rd_data, 128'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus.rk_valid | bus.busy;
        end
        check("post-reset quiet", seen, 1'b0);
        run_key("aes128 after reset", 2'd0, KEY128, 0, 0, 45);

`ifdef AES_KEY_SCHEDULE_STORE_EN
        @(negedge clk);
        rd_addr = 4'd10;
        @(negedge clk);
        check("store rd 10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_addr = 4'd0;
        @(negedge clk);
        check("store rd 0", rd_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_addr = 4'd11;
        @(negedge clk);
        check("store rd 11 beyond Nr", rd_data, 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential, multi-key-size AES key expander. It accepts a 128-, 192- or 256-bit cipher key and streams the 11, 13 or 15 round keys out in order over a valid/ready interface, generating one 32-bit schedule word per clock. It sits between key load and the iterative round datapath. It is the shared successor to the fixed-size, per-round combinational expansion ports.

## Interface
Parameters:
- MAX_NK, 8, largest key size supported in words: 4, 6 or 8. The sliding window holds MAX_NK words. A key_size needing more than MAX_NK words is rejected.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin expansion; sampled only when busy=0.
- key_size  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved.
- key  in  256  cipher key, left-aligned. Word 0 is key[255:224]; unused low words are ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse after the last round key handshake.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts rk_data.
- rk_data  out  128  round key. Word 0 is in bits [127:96].
- rk_idx  out  4  round number, 0..Nr.
- rk_last  out  1  high with the round key whose rk_idx=Nr.

## Operation
- Nk is 4, 6 or 8; Nr is 10, 12 or 14. The schedule produces 4*(Nr+1) words: 44, 52 or 60.
- A start is accepted only when busy=0 and key_size is legal for MAX_NK.
- An illegal start is ignored: busy stays 0 and nothing is emitted.
- On accept:
  - latch Nk and key into the window;
  - set word counter i=0 and rcon=8'h01;
  - set busy=1.
- Each non-stalled cycle produces word w[i] and increments i:
  - i < Nk: w[i] = key word i.
  - i%Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After use, rcon is updated: rcon = xtime(rcon), reducing by 8'h1b on bit-7 carry.
  - Nk == 8 and i%4 == 4 relative to Nk (i%8 == 4): w[i] = w[i-8] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
- RotWord rotates bytes left by one. SubWord applies the AES S-box to each byte using 4 S-box instances.
- Words accumulate in a 4-word assembly register. On the word with i%4 == 3:
  - the register is transferred to the output holding register;
  - rk_valid is set and rk_idx = i/4.
- Stall: if the holding register is still full (rk_valid && !rk_ready) when a new round key would complete, i, the window, rcon and assembly are all frozen.
- After the handshake on rk_last:
  - busy drops and done pulses in the next cycle;
  - rk_valid falls unless a new key is already loaded.
- A start while busy=1 is ignored. A mid-run key or key_size change has no effect.
- Reset mid-operation clears all state immediately; no partial key is emitted afterwards.

## Timing
- Reset values: busy=0, done=0, rk_valid=0, rk_last=0, rk_idx=0, rk_data=0.
- Start is sampled at edge T0. w[i] is registered at edge T0+1+i.
- Round key r is visible from edge T0+4r+4. With rk_ready=1 constantly, rk_valid is high every 4th cycle.
- Total latency from start to done with no backpressure:
  - AES-128: 4*11+1 = 45 cycles.
  - AES-192: 53 cycles.
  - AES-256: 61 cycles.
- Each backpressure cycle on a completing round key adds exactly one cycle.
- rk_data, rk_idx and rk_last are stable while rk_valid && !rk_ready.

## Configuration
- AES_KEY_SCHEDULE_STORE_EN:
  - When defined, adds a 15x128 round-key store written on each handshake, plus ports rd_addr (in, 4) and rd_data (out, 128) with 1-cycle registered read latency. This supports decryption replay in reverse order.
  - rd_data is 0 after reset. Addresses > Nr return 0.
  - When undefined, the ports and storage are absent and the streaming behaviour is identical.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_idx=10 data d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, and done exactly 45 cycles after start.
- AES-192 key 000102…1617 -> rk_idx=12 data a4970a331a78dc09c418c271e3a41d5d, and 13 handshakes in total.
- AES-256 key 000102…1e1f -> rk_idx=14 data 24fc79ccbf0979e9371ac23c6d68de36, with rk_idx=1 data 101112131415161718191a1b1c1d1e1f.
- Random rk_ready toggling on the AES-256 vector -> identical key sequence, data held stable while stalled, no key skipped or duplicated.
- start while busy, key_size=3, and MAX_NK=4 with key_size=2 -> ignored: busy unchanged and no rk_valid.
- rst_n low at round 5, then a fresh AES-128 start -> outputs cleared at once, and the correct full sequence follows. With STORE_EN, rd_addr=10 returns d014f9a8… one cycle later.
